// File: rtl/crc_check_pkg.sv
// Shared types and helpers for the receive-side CRC checker.
package crc_check_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  // The check result trails the last flit by the engine pipeline plus this many cycles.
  localparam int unsigned CHK_LAT_BASE = 2;

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/crc_gen.sv
// Flit-parallel CRC engine: per-packet CRC, result strobed PIPE_LVL+1 cycles after the last flit.
module crc_gen #(
  parameter int unsigned            DWIDTH    = 512,
  parameter int unsigned            CRC_WIDTH = 16,
  parameter int unsigned            PIPE_LVL  = 0,
  parameter logic [CRC_WIDTH-1:0]   CRC_POLY  = 16'hda5f,
  parameter logic [CRC_WIDTH-1:0]   INIT      = '0,
  parameter logic [CRC_WIDTH-1:0]   XOR_OUT   = '0,
  parameter logic                   REFIN     = 1'b0,
  parameter logic                   REFOUT    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DWIDTH-1:0]    din,
  input  logic                 flitEn,
  input  logic                 dlast,
  output logic [CRC_WIDTH-1:0] crc_out,
  output logic                 crc_out_vld
);

  localparam int unsigned NBYTES = DWIDTH / 8;

  logic [CRC_WIDTH-1:0]             crc_q, crc_nxt, crc_rev, crc_fin;
  logic [PIPE_LVL:0][CRC_WIDTH-1:0] pipe_crc;
  logic [PIPE_LVL:0]                pipe_vld;

  // Bytes are consumed first-transmitted first (top of din), each MSB-first after optional reflection.
  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c,
                                                    input logic [DWIDTH-1:0] d);
    logic [CRC_WIDTH-1:0] r;
    logic [7:0]           b;
    logic                 fb;
    r = c;
    for (int i = 0; i < NBYTES; i++) begin
      b = d[DWIDTH-1-8*i -: 8];
      if (REFIN) b = {<<{b}};
      for (int j = 7; j >= 0; j--) begin
        fb = r[CRC_WIDTH-1] ^ b[j];
        r  = {r[CRC_WIDTH-2:0], 1'b0};
        if (fb) r = r ^ CRC_POLY;
      end
    end
    return r;
  endfunction

  always_comb begin
    crc_nxt = crc_step(crc_q, din);
    crc_rev = {<<{crc_nxt}};
    crc_fin = (REFOUT ? crc_rev : crc_nxt) ^ XOR_OUT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q    <= INIT;
      pipe_crc <= '0;
      pipe_vld <= '0;
    end else begin
      if (flitEn) crc_q <= dlast ? INIT : crc_nxt;
      pipe_vld[0] <= flitEn & dlast;
      if (flitEn & dlast) pipe_crc[0] <= crc_fin;
      for (int k = 1; k <= PIPE_LVL; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_crc[k] <= pipe_crc[k-1];
      end
    end
  end

  assign crc_out     = pipe_crc[PIPE_LVL];
  assign crc_out_vld = pipe_vld[PIPE_LVL];

endmodule

// File: rtl/crc_check.sv
// RX CRC checker: recomputes the packet CRC, compares with the delivered FCS, keeps statistics.
module crc_check
  import crc_check_pkg::*;
#(
  parameter int unsigned          DWIDTH    = 512,
  parameter int unsigned          CRC_WIDTH = 16,
  parameter int unsigned          PIPE_LVL  = 0,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 16'hda5f,
  parameter logic [CRC_WIDTH-1:0] INIT      = '0,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT   = '0,
  parameter logic                 REFIN     = 1'b0,
  parameter logic                 REFOUT    = 1'b0,
  parameter int unsigned          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DWIDTH-1:0]    din,
  input  logic                 flitEn,
  input  logic                 dlast,
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic                 stat_clr,
  output logic                 chk_vld,
  output logic                 chk_ok,
  output logic                 chk_err,
  output logic                 err_sticky,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [15:0]          beat_cnt
);

  localparam int unsigned CHK_LAT = PIPE_LVL + CHK_LAT_BASE;
  localparam int unsigned FW      = $clog2(CHK_LAT + 1);

  logic [CRC_WIDTH-1:0]             crc_out;
  logic                             crc_out_vld;
  logic [PIPE_LVL:0][CRC_WIDTH-1:0] fcs_dly;
  logic [FW-1:0]                    flush_cnt;
  logic                             res_take, crc_match;
  state_t                           state, state_nxt;
  logic [15:0]                      beat_q, beat_nxt, beat_cnt_nxt;

  crc_gen #(
    .DWIDTH(DWIDTH), .CRC_WIDTH(CRC_WIDTH), .PIPE_LVL(PIPE_LVL), .CRC_POLY(CRC_POLY),
    .INIT(INIT), .XOR_OUT(XOR_OUT), .REFIN(REFIN), .REFOUT(REFOUT)
  ) u_crc_gen (
    .clk(clk), .rst(rst), .din(din), .flitEn(flitEn), .dlast(dlast),
    .crc_out(crc_out), .crc_out_vld(crc_out_vld)
  );

  // Head stage captures the FCS; the rest advance every cycle to track the engine pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcs_dly <= '0;
    end else begin
      if (flitEn & dlast) fcs_dly[0] <= crc_in;
      for (int k = 1; k <= PIPE_LVL; k++) fcs_dly[k] <= fcs_dly[k-1];
    end
  end

  assign crc_match = (crc_out == fcs_dly[PIPE_LVL]);
  assign res_take  = crc_out_vld & (flush_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= FW'(CHK_LAT - 1);
      chk_vld   <= 1'b0;
      chk_ok    <= 1'b0;
      chk_err   <= 1'b0;
    end else begin
      if (flush_cnt != '0) flush_cnt <= flush_cnt - FW'(1);
      chk_vld <= res_take;
      chk_ok  <= res_take & crc_match;
      chk_err <= res_take & ~crc_match;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat_q;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (flitEn) begin
          if (dlast) begin
            beat_cnt_nxt = 16'd1;
          end else begin
            state_nxt = IN_PKT;
            beat_nxt  = 16'd1;
          end
        end
      end
      IN_PKT: begin
        if (flitEn) begin
          if (dlast) begin
            state_nxt    = IDLE;
            beat_nxt     = '0;
            beat_cnt_nxt = 16'(sat_inc(64'(beat_q), 16));
          end else begin
            beat_nxt = 16'(sat_inc(64'(beat_q), 16));
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_q   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_q   <= beat_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // A clear coinciding with a result wins; that result is not counted.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      pkt_cnt    <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (chk_vld) begin
      pkt_cnt <= CNT_WIDTH'(sat_inc(64'(pkt_cnt), CNT_WIDTH));
      if (chk_err) begin
        err_cnt    <= CNT_WIDTH'(sat_inc(64'(err_cnt), CNT_WIDTH));
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crc_check.sv
// Randomised scoreboard bench for crc_check using CRC-32 (reflected); two builds checked side by side.
module tb_crc_check;

  localparam int DW = 72;
  localparam int CW = 32;

  typedef logic [7:0]    bq_t[$];
  typedef logic [DW-1:0] fq_t[$];
  typedef struct {
    logic ok;
    int   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          flitEn = 1'b0, dlast = 1'b0;
  logic [CW-1:0] crc_in = '0;
  logic          stat_clr0 = 1'b0, stat_clr2 = 1'b0;

  logic        vld0, ok0, err0, sticky0, vld2, ok2, err2, sticky2;
  logic [31:0] pkt0, ec0;
  logic [3:0]  pkt2, ec2;
  logic [15:0] beat0, beat2;

  int   cyc = 0;
  int   total = 0, bad = 0;
  exp_t sbq[2][$];
  logic [63:0] m_pkt[2], m_err[2];
  logic        m_sticky[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_check #(.DWIDTH(DW), .CRC_WIDTH(CW), .PIPE_LVL(0), .CRC_POLY(32'h04C11DB7),
    .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1), .CNT_WIDTH(32))
  u_dut0 (.clk(clk), .rst(rst), .din(din), .flitEn(flitEn), .dlast(dlast), .crc_in(crc_in),
    .stat_clr(stat_clr0), .chk_vld(vld0), .chk_ok(ok0), .chk_err(err0), .err_sticky(sticky0),
    .pkt_cnt(pkt0), .err_cnt(ec0), .beat_cnt(beat0));

  crc_check #(.DWIDTH(DW), .CRC_WIDTH(CW), .PIPE_LVL(2), .CRC_POLY(32'h04C11DB7),
    .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1), .CNT_WIDTH(4))
  u_dut2 (.clk(clk), .rst(rst), .din(din), .flitEn(flitEn), .dlast(dlast), .crc_in(crc_in),
    .stat_clr(stat_clr2), .chk_vld(vld2), .chk_ok(ok2), .chk_err(err2), .err_sticky(sticky2),
    .pkt_cnt(pkt2), .err_cnt(ec2), .beat_cnt(beat2));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference CRC-32: classic LSB-first shift over the packet's byte sequence.
  function automatic logic [31:0] ref_crc(input bq_t bytes);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (bytes[i]) begin
      c ^= {24'd0, bytes[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Counters are compared first (state after the last edge), then the model absorbs this cycle.
  task automatic mon_step(input int id, input int lat, input logic [63:0] maxc,
                          input logic vld, input logic ok, input logic err, input logic sticky,
                          input logic [63:0] pc, input logic [63:0] ec, input logic clr);
    exp_t e;
    bit   ev, ev_err;
    ev = 0;
    ev_err = 0;
    check($sformatf("d%0d_pkt_cnt", id), pc, m_pkt[id]);
    check($sformatf("d%0d_err_cnt", id), ec, m_err[id]);
    check($sformatf("d%0d_err_sticky", id), 64'(sticky), 64'(m_sticky[id]));
    if (vld === 1'b1) begin
      if (sbq[id].size() == 0) begin
        total++;
        bad++;
        $display("FAIL d%0d_spurious_vld: got chk_vld=1 at cycle %0d expected no pending packet", id, cyc);
      end else begin
        e = sbq[id].pop_front();
        check($sformatf("d%0d_chk_ok", id), 64'(ok), 64'(e.ok));
        check($sformatf("d%0d_chk_err", id), 64'(err), 64'(!e.ok));
        check($sformatf("d%0d_latency", id), 64'(cyc - e.cyc), 64'(lat));
        ev = 1;
        ev_err = !e.ok;
      end
    end
    if (rst) begin
      m_pkt[id] = 0; m_err[id] = 0; m_sticky[id] = 0;
      sbq[id].delete();
    end else if (clr) begin
      m_pkt[id] = 0; m_err[id] = 0; m_sticky[id] = 0;
    end else if (ev) begin
      if (m_pkt[id] < maxc) m_pkt[id] = m_pkt[id] + 1;
      if (ev_err) begin
        if (m_err[id] < maxc) m_err[id] = m_err[id] + 1;
        m_sticky[id] = 1;
      end
    end
  endtask

  always @(negedge clk) mon_step(0, 2, 64'hFFFFFFFF, vld0, ok0, err0, sticky0, 64'(pkt0), 64'(ec0), stat_clr0);
  always @(negedge clk) mon_step(1, 4, 64'd15, vld2, ok2, err2, sticky2, 64'(pkt2), 64'(ec2), stat_clr2);

  task automatic drive(input logic [DW-1:0] d, input logic en, input logic last, input logic [CW-1:0] fcs);
    din = d; flitEn = en; dlast = last; crc_in = fcs;
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rnd_flit();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  task automatic push_exp(input logic ok);
    exp_t e;
    e.ok = ok;
    e.cyc = cyc;
    sbq[0].push_back(e);
    sbq[1].push_back(e);
  endtask

  task automatic send_data(input fq_t fl, input int gap_mask, input bit corrupt);
    bq_t         bytes;
    logic [31:0] good, fcs;
    foreach (fl[i]) for (int k = DW/8 - 1; k >= 0; k--) bytes.push_back(fl[i][8*k +: 8]);
    good = ref_crc(bytes);
    fcs = corrupt ? (good ^ (32'd1 << $urandom_range(31, 0))) : good;
    foreach (fl[i]) begin
      if (gap_mask[i]) drive(rnd_flit(), 1'b0, 1'($urandom), $urandom);
      if (i == fl.size() - 1) begin
        push_exp(!corrupt);
        drive(fl[i], 1'b1, 1'b1, fcs);
      end else begin
        drive(fl[i], 1'b1, 1'b0, $urandom);
      end
    end
    flitEn = 1'b0; dlast = 1'b0;
    check("d0_beat_cnt", 64'(beat0), 64'(fl.size()));
    check("d2_beat_cnt", 64'(beat2), 64'(fl.size()));
  endtask

  task automatic rand_pkt(input int n, input int gap_mask, input bit corrupt);
    fq_t fl;
    for (int i = 0; i < n; i++) fl.push_back(rnd_flit());
    send_data(fl, gap_mask, corrupt);
  endtask

  task automatic idle(input int n);
    flitEn = 1'b0; dlast = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    flitEn = 1'b0; dlast = 1'b0;
    while ((sbq[0].size() != 0 || sbq[1].size() != 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("d0_drain_pending", 64'(sbq[0].size()), 64'd0);
    check("d2_drain_pending", 64'(sbq[1].size()), 64'd0);
    sbq[0].delete();
    sbq[1].delete();
    idle(2);
  endtask

  initial begin
    fq_t fl;
    for (int i = 0; i < 2; i++) begin m_pkt[i] = 0; m_err[i] = 0; m_sticky[i] = 0; end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_vld0", 64'(vld0), 0);
    check("rst_ok0", 64'(ok0), 0);
    check("rst_err0", 64'(err0), 0);
    check("rst_beat0", 64'(beat0), 0);
    check("rst_vld2", 64'(vld2), 0);
    check("rst_beat2", 64'(beat2), 0);
    check("rst_pkt2", 64'(pkt2), 0);
    idle(3);

    // Known-answer vector "123456789"
    push_exp(1'b1);
    drive(72'h313233343536373839, 1'b1, 1'b1, 32'hCBF43926);
    check("kat_beat", 64'(beat0), 64'd1);
    idle(5);
    check("kat_pkt_cnt", 64'(pkt0), 64'd1);
    check("kat_err_cnt", 64'(ec0), 64'd0);
    push_exp(1'b0);
    drive(72'h313233343536373839, 1'b1, 1'b1, 32'hCBF43927);
    drain();
    check("kat_bad_sticky", 64'(sticky0), 64'd1);
    check("kat_bad_err_cnt", 64'(ec0), 64'd1);

    // Ten back-to-back single-flit packets, every third corrupted
    for (int i = 1; i <= 10; i++) rand_pkt(1, 0, (i % 3) == 0);
    drain();

    // Same five flits with and without idle gaps
    fl.delete();
    for (int i = 0; i < 5; i++) fl.push_back(rnd_flit());
    send_data(fl, 5'b01010, 1'b0);
    send_data(fl, 0, 1'b0);
    drain();

    // Drive the 4-bit error counter into saturation, then clear coincident with a result
    for (int i = 0; i < 16; i++) rand_pkt(1, 0, 1'b1);
    drain();
    check("d2_err_saturated", 64'(ec2), 64'hF);
    check("d2_pkt_saturated", 64'(pkt2), 64'hF);
    rand_pkt(1, 0, 1'b1);
    idle(1);
    stat_clr0 = 1'b1;
    idle(1);
    stat_clr0 = 1'b0;
    idle(1);
    stat_clr2 = 1'b1;
    idle(1);
    stat_clr2 = 1'b0;
    idle(2);
    check("clr_d0_err_cnt", 64'(ec0), 0);
    check("clr_d0_pkt_cnt", 64'(pkt0), 0);
    check("clr_d0_sticky", 64'(sticky0), 0);
    check("clr_d2_err_cnt", 64'(ec2), 0);
    check("clr_d2_pkt_cnt", 64'(pkt2), 0);
    check("clr_d2_sticky", 64'(sticky2), 0);
    drain();

    // Reset on flit 3 of a 5-flit packet, then a packet right after reset
    rand_pkt(2, 0, 1'b0);
    drain();
    drive(rnd_flit(), 1'b1, 1'b0, $urandom);
    drive(rnd_flit(), 1'b1, 1'b0, $urandom);
    rst = 1'b1;
    drive(rnd_flit(), 1'b1, 1'b0, $urandom);
    rst = 1'b0;
    rand_pkt(1, 0, 1'b0);
    drain();
    check("post_rst_d0_pkt_cnt", 64'(pkt0), 64'd1);
    check("post_rst_d2_pkt_cnt", 64'(pkt2), 64'd1);
    check("post_rst_d0_err_cnt", 64'(ec0), 64'd0);

    // Random traffic with occasional statistics clears
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(7, 0) == 0) begin
        stat_clr0 = 1'($urandom);
        stat_clr2 = 1'($urandom);
        idle(1);
        stat_clr0 = 1'b0;
        stat_clr2 = 1'b0;
      end
      rand_pkt($urandom_range(5, 1), $urandom_range(31, 0) & $urandom_range(31, 0),
               $urandom_range(2, 0) == 0);
      if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000ns");
    $fatal(1);
  end

endmodule

// File: doc/crc_check.md
Name: crc_check

Overview:
- Receive-side counterpart of crc_gen.
- Recomputes the CRC over an incoming flit stream and compares it against the FCS delivered with the last flit of each packet.
- Reports a per-packet pass/fail strobe, and keeps saturating packet, error and beat statistics.
- Sits at the RX datapath boundary, after deserialisation and before the packet buffer that drops bad frames.

Parameters:
- DWIDTH, 512, flit data width in bits.
- CRC_WIDTH, 16, CRC width.
- PIPE_LVL, 0, pipeline levels of the internal CRC engine.
- CRC_POLY, 16'hda5f, generator polynomial.
- INIT, 16'b0, CRC seed at each packet start.
- XOR_OUT, 16'b0, final XOR applied before comparison.
- REFIN, 1'b0, reflect input bits within each byte.
- REFOUT, 1'b0, reflect the computed CRC before XOR_OUT.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- din  in  DWIDTH  flit data; the first-transmitted byte is in din[DWIDTH-1 -: 8].
- flitEn  in  1  flit valid qualifier.
- dlast  in  1  last flit of packet; only meaningful when flitEn=1.
- crc_in  in  CRC_WIDTH  received FCS; sampled only when flitEn & dlast.
- stat_clr  in  1  synchronous clear of the statistics counters.
- chk_vld  out  1  one-cycle strobe: the check result is valid.
- chk_ok  out  1  computed CRC equals crc_in; qualified by chk_vld.
- chk_err  out  1  mismatch; qualified by chk_vld; always the complement of chk_ok when chk_vld=1.
- err_sticky  out  1  set on any mismatch; cleared only by rst or stat_clr.
- pkt_cnt  out  CNT_WIDTH  packets checked; saturating.
- err_cnt  out  CNT_WIDTH  packets failed; saturating.
- beat_cnt  out  16  flit count of the most recently completed packet; saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - All outputs are 0.
  - The CRC engine state returns to INIT.
  - The crc_in delay line, beat counter and state are cleared.
- CRC engine:
  - Instantiates crc_gen with identical parameters, driving din/flitEn/dlast straight through.
  - Its crc_out/crc_out_vld appear PIPE_LVL+1 cycles after the last flit.
- FCS alignment:
  - crc_in is captured when flitEn & dlast.
  - It is delayed through a PIPE_LVL+1 stage shift register so it arrives in the same cycle as crc_out_vld.
  - Non-last flits do not shift the delay line; the delay is a fixed per-cycle pipeline, so back-to-back last flits remain aligned.
- Compare stage:
  - Registered; chk_vld rises PIPE_LVL+2 cycles after the flitEn & dlast cycle.
  - chk_ok = (crc_out == crc_in_dly) and chk_err = ~chk_ok, both valid for one cycle only.
- State machine, two states:
  - IDLE: flitEn & ~dlast → IN_PKT and beat counter := 1. flitEn & dlast (single-flit packet) → stays IDLE and beat_cnt := 1.
  - IN_PKT: each flitEn increments the beat counter (saturating). flitEn & dlast → IDLE and beat_cnt := final count.
- Statistics:
  - pkt_cnt increments on chk_vld; err_cnt increments on chk_vld & chk_err.
  - Both saturate at all-ones.
  - stat_clr zeroes pkt_cnt, err_cnt and err_sticky. If stat_clr coincides with chk_vld, the clear wins and the event is not counted.
- Throughput: one flit per cycle with no bubbles required. Consecutive single-flit packets produce consecutive chk_vld strobes.
- Idle cycles: flitEn=0 gaps inside a packet are allowed. The CRC state and beat counter hold.
- Reset mid-packet:
  - The packet is discarded and no chk_vld is produced for it.
  - Pipelined results in flight are also dropped; chk_vld is forced to 0 for PIPE_LVL+2 cycles after rst deasserts, via an internal flush counter.

Decomposition:
- Package crc_check_pkg holds:
  - the state enum typedef (IDLE, IN_PKT);
  - the localparam CHK_LAT = PIPE_LVL+2;
  - a saturating-increment function shared by all counters.
- Sub-module: crc_gen (existing), instantiated once. No other sub-module is needed.

Test Plan:
- Config CRC_WIDTH=32, DWIDTH=72, CRC_POLY=32'h04C11DB7, INIT=XOR_OUT=32'hFFFFFFFF, REFIN=REFOUT=1, PIPE_LVL=0:
  - Scenario 1: single flit "123456789" (din=72'h313233343536373839), dlast=1, crc_in=32'hCBF43926 → chk_vld at +2 cycles, chk_ok=1, pkt_cnt=1, err_cnt=0, beat_cnt=1.
  - Scenario 2: same flit with crc_in=32'hCBF43927 → chk_err=1, err_sticky=1, err_cnt=1.
- Scenario 3: PIPE_LVL=2, ten back-to-back single-flit packets, every third FCS corrupted → ten consecutive chk_vld strobes starting 4 cycles after the first flit, err_cnt=3 (packets 3, 6, 9), pkt_cnt=10.
- Scenario 4: 5-flit packet with two flitEn=0 gaps and a correct FCS → chk_ok=1, beat_cnt=5; the same data without gaps yields an identical CRC.
- Scenario 5: rst asserted on flit 3 of a 5-flit packet, then a clean 1-flit packet → no chk_vld for the aborted packet; the next packet passes with pkt_cnt=1.
- Scenario 6: preload err_cnt to all-ones via a forced CNT_WIDTH=4 build with 16 bad packets, then stat_clr coincident with a 17th chk_vld → err_cnt holds 4'hF through saturation, then reads 0 after the clear, and err_sticky=0.
